mem_port_arbiter: RTL and testbench

- Sequences a single shared memory port between two requesters: port 0 is instruction fetch and port 1 is load/store.
- Drives the select of the 32-bit 2:1 address/data muxes in front of the memory, plus the memory request and write-enable strobes.
- Round-robin arbitration with a registered FSM. Completion is signalled to the winning requester by a one-cycle done pulse carrying registered read data.

---
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester/memory handshake bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we1;
  logic              mux_sel;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata;
  logic              done0;
  logic              done1;
  logic              err;
  logic              busy;

  modport master (
    output req0, req1, we1, mem_ack, mem_rdata,
    input  mux_sel, mem_req, mem_we, rdata, done0, done1, err, busy
  );

  modport slave (
    input  req0, req1, we1, mem_ack, mem_rdata,
    output mux_sel, mem_req, mem_we, rdata, done0, done1, err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
// Optional grant timeout enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DONE} state_t;

  generate
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be within 1..255");
    end
  endgenerate

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              done_port_q, done_port_d;
  logic              mux_sel_q, mux_sel_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      done_port_q  <= 1'b0;
      mux_sel_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      rdata_q      <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= 8'd0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      done_port_q  <= done_port_d;
      mux_sel_q    <= mux_sel_d;
      mem_we_q     <= mem_we_d;
      rdata_q      <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    done_port_d  = done_port_q;
    mux_sel_d    = mux_sel_q;
    mem_we_d     = mem_we_q;
    rdata_d      = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        // On a tie port 0 wins only when port 1 was granted last.
        if (bus.req0 && (!bus.req1 || last_grant_q)) begin
          state_d      = GRANT0;
          mux_sel_d    = 1'b0;
          mem_we_d     = 1'b0;
          last_grant_d = 1'b0;
        end else if (bus.req1) begin
          state_d      = GRANT1;
          mux_sel_d    = 1'b1;
          mem_we_d     = bus.we1;
          last_grant_d = 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        cnt_d     = 8'd0;
        timeout_d = 1'b0;
`endif
      end
      GRANT0, GRANT1: begin
        if (bus.mem_ack) begin
          state_d     = DONE;
          rdata_d     = bus.mem_rdata;
          done_port_d = (state_q == GRANT1);
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d     = DONE;
          rdata_d     = '0;
          done_port_d = (state_q == GRANT1);
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mux_sel = mux_sel_q;
    bus.mem_req = (state_q == GRANT0) || (state_q == GRANT1);
    bus.mem_we  = mem_we_q && ((state_q == GRANT0) || (state_q == GRANT1));
    bus.rdata   = rdata_q;
    bus.done0   = (state_q == DONE) && !done_port_q;
    bus.done1   = (state_q == DONE) && done_port_q;
    bus.busy    = (state_q != IDLE);
`ifdef MEM_TIMEOUT_EN
    bus.err     = (state_q == DONE) && timeout_q;
`else
    bus.err     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  mem_port_arbiter_if #(.DATA_W(32)) bus ();

  mem_port_arbiter #(.DATA_W(32), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we1 = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Packs {busy, mem_req, mem_we, mux_sel, done0, done1, err} for compact checks.
  function automatic logic [6:0] ctl();
    return {bus.busy, bus.mem_req, bus.mem_we, bus.mux_sel, bus.done0, bus.done1, bus.err};
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (ctl() !== 7'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 7'b0); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus.req0 = 1'b1;
    step();
    total++; if (ctl() !== 7'b1100000) begin bad++; $display("FAIL fetch_grant got=%b exp=%b", ctl(), 7'b1100000); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0013;
    step();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF; bus.req0 = 1'b0;
    total++; if (ctl() !== 7'b1000100) begin bad++; $display("FAIL fetch_done got=%b exp=%b", ctl(), 7'b1000100); end
    total++; if (bus.rdata !== 32'h0000_0013) begin bad++; $display("FAIL fetch_rdata got=%h exp=%h", bus.rdata, 32'h13); end
    step();
    total++; if (ctl() !== 7'b0000000) begin bad++; $display("FAIL fetch_idle got=%b exp=%b", ctl(), 7'b0); end
    total++; if (bus.rdata !== 32'h0000_0013) begin bad++; $display("FAIL fetch_hold got=%h exp=%h", bus.rdata, 32'h13); end
  endtask

  task automatic test_tie_round_robin();
    logic exp_sel;
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_sel = (i % 2 == 1);
      step();
      total++; if (bus.mem_req !== 1'b1 || bus.mux_sel !== exp_sel) begin
        bad++; $display("FAIL rr_grant%0d got req=%b sel=%b exp req=1 sel=%b", i, bus.mem_req, bus.mux_sel, exp_sel); end
      step();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA0 + 32'(i);
      step();
      bus.mem_ack = 1'b0;
      total++; if ({bus.done0, bus.done1} !== {!exp_sel, exp_sel}) begin
        bad++; $display("FAIL rr_done%0d got=%b exp=%b", i, {bus.done0, bus.done1}, {!exp_sel, exp_sel}); end
      total++; if (bus.rdata !== 32'hA0 + 32'(i)) begin
        bad++; $display("FAIL rr_rdata%0d got=%h exp=%h", i, bus.rdata, 32'hA0 + 32'(i)); end
      step();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_idle%0d got=%b exp=0", i, bus.busy); end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_write_and_deferred();
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 0) begin bus.req0 = 1'b1; bus.we1 = 1'b0; end
      if (c == 2) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0055; end
      total++; if (ctl() !== 7'b1111000) begin
        bad++; $display("FAIL wr_grant_c%0d got=%b exp=%b", c, ctl(), 7'b1111000); end
    end
    step();
    bus.mem_ack = 1'b0; bus.req1 = 1'b0;
    total++; if (ctl() !== 7'b1001010) begin bad++; $display("FAIL wr_done got=%b exp=%b", ctl(), 7'b1001010); end
    total++; if (bus.rdata !== 32'h0000_0055) begin bad++; $display("FAIL wr_rdata got=%h exp=%h", bus.rdata, 32'h55); end
    step();
    total++; if (ctl() !== 7'b0001000) begin bad++; $display("FAIL wr_idle got=%b exp=%b", ctl(), 7'b0001000); end
    step();
    total++; if (ctl() !== 7'b1100000) begin bad++; $display("FAIL wr_next_grant0 got=%b exp=%b", ctl(), 7'b1100000); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0066;
    step();
    bus.mem_ack = 1'b0; bus.req0 = 1'b0;
    total++; if (bus.done0 !== 1'b1 || bus.rdata !== 32'h66) begin
      bad++; $display("FAIL wr_next_done got done0=%b rdata=%h exp done0=1 rdata=66", bus.done0, bus.rdata); end
    step();
  endtask

  task automatic test_reset_abort();
    do_reset();
    bus.req0 = 1'b1;
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0077;
    step();
    bus.mem_ack = 1'b0;
    step();
    bus.req1 = 1'b1; bus.we1 = 1'b1;
    step();
    total++; if (ctl() !== 7'b1111000) begin bad++; $display("FAIL abort_pre got=%b exp=%b", ctl(), 7'b1111000); end
    rst = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we1 = 1'b0;
    step();
    rst = 1'b0;
    total++; if (ctl() !== 7'b0 || bus.rdata !== 32'h0) begin
      bad++; $display("FAIL abort_reset got ctl=%b rdata=%h exp ctl=0 rdata=0", ctl(), bus.rdata); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_DEAD;
    step();
    bus.mem_ack = 1'b0;
    total++; if (ctl() !== 7'b0 || bus.rdata !== 32'h0) begin
      bad++; $display("FAIL abort_spurious_ack got ctl=%b rdata=%h exp ctl=0 rdata=0", ctl(), bus.rdata); end
    step();
    total++; if (ctl() !== 7'b0) begin bad++; $display("FAIL abort_after got=%b exp=0", ctl()); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles;
    do_reset();
    bus.req1 = 1'b1;
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0077;
    step();
    bus.mem_ack = 1'b0; bus.req1 = 1'b0;
    step();
    bus.req1 = 1'b1;
    req_cycles = 0;
    for (int c = 0; c < 20 && !bus.done1; c++) begin
      step();
      if (bus.mem_req) req_cycles++;
    end
    bus.req1 = 1'b0;
    total++; if (req_cycles !== 15) begin bad++; $display("FAIL to_req_cycles got=%0d exp=15", req_cycles); end
    total++; if ({bus.done1, bus.err, bus.mem_req} !== 3'b110 || bus.rdata !== 32'h0) begin
      bad++; $display("FAIL to_done got done1/err/req=%b rdata=%h exp 110 rdata=0", {bus.done1, bus.err, bus.mem_req}, bus.rdata); end
    step();
    bus.req1 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (c == 14) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0099; end
    end
    step();
    bus.mem_ack = 1'b0; bus.req1 = 1'b0;
    total++; if ({bus.done1, bus.err} !== 2'b10 || bus.rdata !== 32'h99) begin
      bad++; $display("FAIL to_ack_limit got done1/err=%b rdata=%h exp 10 rdata=99", {bus.done1, bus.err}, bus.rdata); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_fetch();
    test_tie_round_robin();
    test_write_and_deferred();
    test_reset_abort();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
